// File: rtl/rout_port_xy_buffer_pkg.sv
// Shared router definitions: port indices, one-hot port type, header field offsets,
// FSM state encoding and the dimension-ordered XY route function.
package rout_port_xy_buffer_pkg;

  localparam int unsigned NUM_PORTS   = 5;
  localparam int unsigned COORD_MAX_W = 16;

  typedef logic [2:0]           port_idx_t;
  typedef logic [NUM_PORTS-1:0] port_oh_t;

  localparam port_idx_t PORT_LOCAL = 3'd0;
  localparam port_idx_t PORT_NORTH = 3'd1;
  localparam port_idx_t PORT_EAST  = 3'd2;
  localparam port_idx_t PORT_SOUTH = 3'd3;
  localparam port_idx_t PORT_WEST  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } rout_state_t;

  // Header is MSB first: src_x, src_y, dst_x, dst_y, mtype, data.
  function automatic int unsigned hdr_dst_x_lsb(input int unsigned bus_w,
                                                input int unsigned coord_w);
    return bus_w - 3 * coord_w;
  endfunction

  function automatic int unsigned hdr_dst_y_lsb(input int unsigned bus_w,
                                                input int unsigned coord_w);
    return bus_w - 4 * coord_w;
  endfunction

  function automatic port_idx_t xy_route(input logic [COORD_MAX_W-1:0] dst_x,
                                         input logic [COORD_MAX_W-1:0] dst_y,
                                         input logic [COORD_MAX_W-1:0] local_x,
                                         input logic [COORD_MAX_W-1:0] local_y);
    if (dst_x > local_x)      return PORT_EAST;
    else if (dst_x < local_x) return PORT_WEST;
    else if (dst_y > local_y) return PORT_NORTH;
    else if (dst_y < local_y) return PORT_SOUTH;
    else                      return PORT_LOCAL;
  endfunction

  function automatic port_oh_t port_onehot(input port_idx_t idx);
    return port_oh_t'(1) << idx;
  endfunction

endpackage

// File: rtl/rout_sync_fifo.sv
// Synchronous FIFO shared by the router input ports; no bypass, head shown combinationally.
module rout_sync_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/rout_port_xy_buffer.sv
// Router input port: buffers beats, XY-routes each packet header, forwards the packet
// wormhole-style to one of five ports, and drops/counts packets addressed outside the mesh.
module rout_port_xy_buffer
  import rout_port_xy_buffer_pkg::*;
#(
  parameter int unsigned COORD_W = 4,
  parameter int unsigned MTYPE_W = 8,
  parameter int unsigned BUS_W   = 32,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned MESH_X  = 4,
  parameter int unsigned MESH_Y  = 4,
  parameter int unsigned LOCAL_X = 0,
  parameter int unsigned LOCAL_Y = 0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic [BUS_W-1:0] s_tdata,
  input  logic             s_tlast,
  output logic [4:0]       m_tvalid,
  input  logic [4:0]       m_tready,
  output logic [BUS_W-1:0] m_tdata,
  output logic             m_tlast,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             busy
);

  localparam int unsigned DSTX_LSB = hdr_dst_x_lsb(BUS_W, COORD_W);
  localparam int unsigned DSTY_LSB = hdr_dst_y_lsb(BUS_W, COORD_W);

  if (BUS_W <= 4 * COORD_W + MTYPE_W) begin : g_bad_bus_w
    $error("BUS_W too small for header fields");
  end

  rout_state_t        r_state;
  port_idx_t          r_route;
  logic [CNT_W-1:0]   r_drop_cnt;

  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [BUS_W:0]     w_head;
  logic [BUS_W-1:0]   w_head_data;
  logic               w_head_last;
  logic [COORD_W-1:0] w_dst_x;
  logic [COORD_W-1:0] w_dst_y;
  logic               w_in_mesh;
  port_idx_t          w_route;
  port_oh_t           w_route_oh;
  logic               w_pop;

  assign s_tready = !rst && !w_fifo_full;

  rout_sync_fifo #(
    .WIDTH (BUS_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (s_tvalid && s_tready),
    .i_pop   (w_pop),
    .i_data  ({s_tlast, s_tdata}),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_head  (w_head)
  );

  assign w_head_data = w_head[BUS_W-1:0];
  assign w_head_last = w_head[BUS_W];
  assign w_dst_x     = w_head_data[DSTX_LSB +: COORD_W];
  assign w_dst_y     = w_head_data[DSTY_LSB +: COORD_W];
  assign w_in_mesh   = (COORD_MAX_W'(w_dst_x) < COORD_MAX_W'(MESH_X)) &&
                       (COORD_MAX_W'(w_dst_y) < COORD_MAX_W'(MESH_Y));
  assign w_route     = xy_route(COORD_MAX_W'(w_dst_x), COORD_MAX_W'(w_dst_y),
                                COORD_MAX_W'(LOCAL_X), COORD_MAX_W'(LOCAL_Y));
  assign w_route_oh  = port_onehot(r_route);

  // Only the locked port's ready can release a beat while forwarding.
  assign w_pop = !w_fifo_empty &&
                 (((r_state == ST_FWD) && |(m_tready & w_route_oh)) ||
                  (r_state == ST_DROP));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_route    <= PORT_LOCAL;
      r_drop_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_fifo_empty) begin
            if (w_in_mesh) begin
              r_route <= w_route;
              r_state <= ST_FWD;
            end else begin
              r_state <= ST_DROP;
            end
          end
        end
        ST_FWD: begin
          if (w_pop && w_head_last) r_state <= ST_IDLE;
        end
        ST_DROP: begin
          if (w_pop && w_head_last) begin
            r_state <= ST_IDLE;
            if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m_tvalid = ((r_state == ST_FWD) && !w_fifo_empty) ? w_route_oh : '0;
  assign m_tdata  = w_fifo_empty ? '0 : w_head_data;
  assign m_tlast  = !w_fifo_empty && w_head_last;
  assign drop_cnt = r_drop_cnt;
  assign busy     = !w_fifo_empty || (r_state != ST_IDLE);

endmodule

// File: tb/tb_rout_port_xy_buffer.sv
// Directed bench for rout_port_xy_buffer with node at (1,1) in a 4x4 mesh, 2-bit drop counter.
module tb_rout_port_xy_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] s_tdata;
  logic        s_tlast;
  logic [4:0]  m_tvalid;
  logic [4:0]  m_tready;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic [1:0]  drop_cnt;
  logic        busy;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;
  int unsigned valid_cycles = 0;
  int unsigned multi_hot    = 0;

  typedef struct {
    logic [4:0]  port;
    logic [31:0] data;
    logic        last;
    int unsigned cyc;
  } obs_t;
  obs_t obs_q[$];

  always #5 clk = ~clk;

  rout_port_xy_buffer #(
    .COORD_W (4),
    .MTYPE_W (8),
    .BUS_W   (32),
    .DEPTH   (8),
    .MESH_X  (4),
    .MESH_Y  (4),
    .LOCAL_X (1),
    .LOCAL_Y (1),
    .CNT_W   (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .s_tlast  (s_tlast),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_tlast  (m_tlast),
    .drop_cnt (drop_cnt),
    .busy     (busy)
  );

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (m_tvalid != 5'b0) valid_cycles++;
      if ($countones(m_tvalid) > 1) multi_hot++;
      if (|(m_tvalid & m_tready)) obs_q.push_back('{m_tvalid, m_tdata, m_tlast, cyc});
    end
  end

  function automatic logic [31:0] hdr(input logic [3:0] dx, input logic [3:0] dy,
                                      input logic [7:0] tag);
    return {4'h0, 4'h0, dx, dy, 8'hA5, tag};
  endfunction

  task automatic send_beat(input logic [31:0] d, input logic l);
    int unsigned n = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    @(negedge clk);
    while (s_tready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (s_tready !== 1'b1) begin
      total++; bad++;
      $display("FAIL send_timeout s_tready=%b required=1", s_tready);
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle_timeout busy=%b required=0", tag, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL rst_s_tready got=%b exp=0", s_tready); end
    total++; if (m_tvalid !== 5'b0) begin bad++; $display("FAIL rst_m_tvalid got=%b exp=00000", m_tvalid); end
    total++; if (m_tdata !== 32'h0) begin bad++; $display("FAIL rst_m_tdata got=%h exp=0", m_tdata); end
    total++; if (m_tlast !== 1'b0) begin bad++; $display("FAIL rst_m_tlast got=%b exp=0", m_tlast); end
    total++; if (drop_cnt !== 2'd0) begin bad++; $display("FAIL rst_drop_cnt got=%0d exp=0", drop_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL rst_release_s_tready got=%b exp=1", s_tready); end
  endtask

  task automatic test_single_beat;
    logic [31:0] h;
    h = hdr(4'd3, 4'd0, 8'h11);
    m_tready = 5'b11111;
    obs_q.delete();
    send_beat(h, 1'b1);
    total++; if (m_tvalid !== 5'b0) begin bad++; $display("FAIL single_bubble got=%b exp=00000", m_tvalid); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy); end
    @(posedge clk); #1;
    total++; if (m_tvalid !== 5'b00100) begin bad++; $display("FAIL single_east_valid got=%b exp=00100", m_tvalid); end
    total++; if (m_tdata !== h) begin bad++; $display("FAIL single_data got=%h exp=%h", m_tdata, h); end
    total++; if (m_tlast !== 1'b1) begin bad++; $display("FAIL single_last got=%b exp=1", m_tlast); end
    @(posedge clk); #1;
    total++; if (m_tvalid !== 5'b0) begin bad++; $display("FAIL single_after got=%b exp=00000", m_tvalid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle busy=%b exp=0", busy); end
    total++; if (drop_cnt !== 2'd0) begin bad++; $display("FAIL single_drop_cnt got=%0d exp=0", drop_cnt); end
    total++; if (obs_q.size() != 1) begin bad++; $display("FAIL single_count got=%0d exp=1", obs_q.size()); end
  endtask

  task automatic test_stall;
    logic [31:0] d [4];
    d[0] = hdr(4'd1, 4'd3, 8'h21);
    for (int i = 1; i < 4; i++) d[i] = 32'hB0B0_0020 + 32'(i);
    m_tready = 5'b0;
    obs_q.delete();
    for (int i = 0; i < 4; i++) send_beat(d[i], i == 3);
    @(negedge clk);
    total++; if (m_tvalid !== 5'b00010) begin bad++; $display("FAIL stall_north_valid got=%b exp=00010", m_tvalid); end
    total++; if (m_tdata !== d[0]) begin bad++; $display("FAIL stall_head got=%h exp=%h", m_tdata, d[0]); end
    @(posedge clk); #1;
    m_tready = 5'b00010;
    repeat (2) @(posedge clk);
    #1;
    m_tready = 5'b11101;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (m_tvalid !== 5'b00010 || m_tdata !== d[2] || m_tlast !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold c=%0d valid=%b data=%h last=%b exp valid=00010 data=%h last=0",
                 c, m_tvalid, m_tdata, m_tlast, d[2]);
      end
      @(posedge clk); #1;
    end
    m_tready = 5'b11111;
    wait_idle("stall");
    total++;
    if (obs_q.size() != 4) begin
      bad++; $display("FAIL stall_count got=%0d exp=4", obs_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (obs_q[i].port !== 5'b00010 || obs_q[i].data !== d[i] || obs_q[i].last !== (i == 3)) begin
          bad++;
          $display("FAIL stall_beat%0d port=%b data=%h last=%b exp port=00010 data=%h last=%b",
                   i, obs_q[i].port, obs_q[i].data, obs_q[i].last, d[i], (i == 3));
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d [4];
    logic [4:0]  p [4];
    d[0] = hdr(4'd1, 4'd1, 8'h31); d[1] = 32'hCAFE_0032;
    d[2] = hdr(4'd0, 4'd2, 8'h33); d[3] = 32'hCAFE_0034;
    p[0] = 5'b00001; p[1] = 5'b00001; p[2] = 5'b10000; p[3] = 5'b10000;
    m_tready = 5'b11111;
    obs_q.delete();
    for (int i = 0; i < 4; i++) send_beat(d[i], (i % 2) == 1);
    wait_idle("b2b");
    total++;
    if (obs_q.size() != 4) begin
      bad++; $display("FAIL b2b_count got=%0d exp=4", obs_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (obs_q[i].port !== p[i] || obs_q[i].data !== d[i] || obs_q[i].last !== ((i % 2) == 1)) begin
          bad++;
          $display("FAIL b2b_beat%0d port=%b data=%h last=%b exp port=%b data=%h",
                   i, obs_q[i].port, obs_q[i].data, obs_q[i].last, p[i], d[i]);
        end
      end
      total++;
      if (obs_q[1].cyc - obs_q[0].cyc != 1 || obs_q[2].cyc - obs_q[1].cyc != 2 ||
          obs_q[3].cyc - obs_q[2].cyc != 1) begin
        bad++;
        $display("FAIL b2b_spacing gaps=%0d,%0d,%0d exp=1,2,1", obs_q[1].cyc - obs_q[0].cyc,
                 obs_q[2].cyc - obs_q[1].cyc, obs_q[3].cyc - obs_q[2].cyc);
      end
    end
  endtask

  task automatic test_full;
    logic [31:0] e [10];
    e[0] = hdr(4'd2, 4'd1, 8'h41);
    for (int i = 1; i < 10; i++) e[i] = 32'hC000_0040 + 32'(i);
    m_tready = 5'b0;
    obs_q.delete();
    for (int i = 0; i < 8; i++) send_beat(e[i], 1'b0);
    @(negedge clk);
    total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL full_s_tready got=%b exp=0", s_tready); end
    total++; if (m_tvalid !== 5'b00100) begin bad++; $display("FAIL full_valid got=%b exp=00100", m_tvalid); end
    fork
      begin
        send_beat(e[8], 1'b0);
        send_beat(e[9], 1'b1);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL full_hold_s_tready got=%b exp=0", s_tready); end
        m_tready = 5'b11111;
      end
    join
    wait_idle("full");
    total++;
    if (obs_q.size() != 10) begin
      bad++; $display("FAIL full_count got=%0d exp=10", obs_q.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        total++;
        if (obs_q[i].port !== 5'b00100 || obs_q[i].data !== e[i] || obs_q[i].last !== (i == 9)) begin
          bad++;
          $display("FAIL full_beat%0d port=%b data=%h last=%b exp port=00100 data=%h",
                   i, obs_q[i].port, obs_q[i].data, obs_q[i].last, e[i]);
        end
      end
    end
  endtask

  task automatic test_drop;
    m_tready = 5'b11111;
    obs_q.delete();
    valid_cycles = 0;
    send_beat(hdr(4'd5, 4'd0, 8'h51), 1'b0);
    send_beat(32'hDEAD_0052, 1'b0);
    send_beat(32'hDEAD_0053, 1'b1);
    wait_idle("drop");
    total++; if (drop_cnt !== 2'd1) begin bad++; $display("FAIL drop_cnt1 got=%0d exp=1", drop_cnt); end
    total++; if (valid_cycles != 0) begin bad++; $display("FAIL drop_no_valid got=%0d exp=0", valid_cycles); end
    send_beat(hdr(4'd3, 4'd3, 8'h55), 1'b1);
    wait_idle("drop_next");
    total++;
    if (obs_q.size() != 1 || obs_q[0].port !== 5'b00100) begin
      bad++; $display("FAIL drop_next_route count=%0d exp=1 port exp=00100", obs_q.size());
    end
    total++; if (drop_cnt !== 2'd1) begin bad++; $display("FAIL drop_cnt_keep got=%0d exp=1", drop_cnt); end
    for (int i = 0; i < 2; i++) begin
      send_beat(hdr(4'd0, 4'd4, 8'h60 + 8'(i)), 1'b1);
      wait_idle("drop_y");
    end
    total++; if (drop_cnt !== 2'd3) begin bad++; $display("FAIL drop_cnt3 got=%0d exp=3", drop_cnt); end
    for (int i = 0; i < 2; i++) begin
      send_beat(hdr(4'd0, 4'd4, 8'h62 + 8'(i)), 1'b1);
      wait_idle("drop_sat");
    end
    total++; if (drop_cnt !== 2'd3) begin bad++; $display("FAIL drop_cnt_sat got=%0d exp=3", drop_cnt); end
  endtask

  task automatic test_reset_mid_packet;
    logic [31:0] f [4];
    logic [31:0] h;
    f[0] = hdr(4'd2, 4'd2, 8'h61);
    for (int i = 1; i < 4; i++) f[i] = 32'hF00D_0060 + 32'(i);
    m_tready = 5'b0;
    for (int i = 0; i < 4; i++) send_beat(f[i], i == 3);
    m_tready = 5'b00100;
    @(posedge clk); #1;
    m_tready = 5'b0;
    total++; if (m_tvalid !== 5'b00100 || m_tdata !== f[1]) begin
      bad++; $display("FAIL rmid_beat2 valid=%b data=%h exp 00100 %h", m_tvalid, m_tdata, f[1]);
    end
    rst = 1'b1;
    #1;
    total++; if (m_tvalid !== 5'b0) begin bad++; $display("FAIL rmid_valid got=%b exp=00000", m_tvalid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    total++; if (drop_cnt !== 2'd0) begin bad++; $display("FAIL rmid_drop_cnt got=%0d exp=0", drop_cnt); end
    total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL rmid_s_tready got=%b exp=0", s_tready); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_tready = 5'b11111;
    obs_q.delete();
    h = hdr(4'd1, 4'd0, 8'h71);
    send_beat(h, 1'b1);
    wait_idle("rmid");
    total++;
    if (obs_q.size() != 1 || obs_q[0].port !== 5'b01000 || obs_q[0].data !== h) begin
      bad++; $display("FAIL rmid_south count=%0d exp=1 port exp=01000 data exp=%h", obs_q.size(), h);
    end
  endtask

  initial begin
    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    m_tready = 5'b0;
    test_reset();
    test_single_beat();
    test_stall();
    test_back_to_back();
    test_full();
    test_drop();
    test_reset_mid_packet();
    total++;
    if (multi_hot != 0) begin bad++; $display("FAIL onehot cycles=%0d exp=0", multi_hot); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
